// File: rtl/sequence_detect_logger.sv
// Logs the stream index of each 1011 detection into a FWFT FIFO.
// Build option: SEQ_LOG_OVERWRITE_EN makes a full FIFO drop its oldest entry.
module sequence_detect_logger #(
  parameter int DEPTH = 8,
  parameter int POS_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       bit_valid,
  input  logic                       detector_in,
  input  logic                       clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [POS_W-1:0]           evt_pos,
  output logic [CNT_W-1:0]           evt_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [POS_W-1:0] mem_q [DEPTH];

  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    level_q, level_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic             ovf_q, ovf_d;

  logic det, pop, full;
  logic wr_en, rd_adv;

  // Push/pop decisions, pointer/level/counter updates and head prefetch
  always_comb begin
    det    = bit_valid & detector_in;
    pop    = (level_q != '0) & evt_ready;
    full   = (level_q == LW'(DEPTH));
`ifdef SEQ_LOG_OVERWRITE_EN
    wr_en  = det;
    rd_adv = pop | (det & full);
`else
    wr_en  = det & (~full | pop);
    rd_adv = pop;
`endif
    pos_d   = bit_valid ? pos_q + POS_W'(1) : pos_q;
    rd_d    = rd_adv ? rd_q + AW'(1) : rd_q;
    wr_d    = wr_en ? wr_q + AW'(1) : wr_q;
    level_d = level_q;
    if (wr_en && !rd_adv) begin
      level_d = level_q + LW'(1);
    end else if (rd_adv && !wr_en) begin
      level_d = level_q - LW'(1);
    end
    cnt_d = cnt_q;
    if (det && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    ovf_d = ovf_q | (det & full & ~pop);
    // Register the next head so evt_pos comes straight from a flop;
    // an entry written into the slot that becomes head bypasses memory.
    head_d = head_q;
    if (level_d != '0) begin
      if (wr_en && (wr_q == rd_d)) begin
        head_d = pos_q;
      end else begin
        head_d = mem_q[rd_d];
      end
    end
    if (clear) begin
      wr_en   = 1'b0;
      rd_adv  = 1'b0;
      pos_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      level_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      head_d  = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q   <= '0;
      head_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem_q[wr_q] <= pos_q;
    end
  end

  assign evt_valid  = (level_q != '0);
  assign evt_pos    = head_q;
  assign evt_count  = cnt_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sequence_detect_logger.sv
// Directed vector bench for sequence_detect_logger.
// Expectations follow SEQ_LOG_OVERWRITE_EN when defined.
module tb_sequence_detect_logger;

`ifdef SEQ_LOG_OVERWRITE_EN
  localparam int OWO = 1;
`else
  localparam int OWO = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        bit_valid, detector_in, clear, evt_ready;
  logic        evt_valid;
  logic [15:0] evt_pos;
  logic [7:0]  evt_count;
  logic [3:0]  fifo_level;
  logic        overflow;

  logic        bv2, din2, clr2, rdy2;
  logic        evt_valid2;
  logic [3:0]  evt_pos2;
  logic [2:0]  evt_count2;
  logic [3:0]  fifo_level2;
  logic        overflow2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  sequence_detect_logger dut (
    .clock(clock), .reset(reset),
    .bit_valid(bit_valid), .detector_in(detector_in),
    .clear(clear), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_pos(evt_pos),
    .evt_count(evt_count), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  sequence_detect_logger #(.DEPTH(8), .POS_W(4), .CNT_W(3)) dut2 (
    .clock(clock), .reset(reset),
    .bit_valid(bv2), .detector_in(din2),
    .clear(clr2), .evt_valid(evt_valid2),
    .evt_ready(rdy2), .evt_pos(evt_pos2),
    .evt_count(evt_count2), .fifo_level(fifo_level2),
    .overflow(overflow2)
  );

  typedef struct {
    logic bv, din, rdy, clr;
    logic v;
    int   p, c, l;
    logic o;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    logic bv, logic din, logic rdy, logic clr,
    logic v, int p, int c, int l, logic o);
    vec_t t;
    t.bv = bv; t.din = din; t.rdy = rdy; t.clr = clr;
    t.v = v; t.p = p; t.c = c; t.l = l; t.o = o;
    tbl.push_back(t);
  endfunction

  task automatic chk(string nm, logic v, int p, int c, int l, logic o);
    n_vec++;
    if (evt_valid !== v || int'(evt_pos) != p ||
        int'(evt_count) != c || int'(fifo_level) != l ||
        overflow !== o) begin
      n_bad++;
      $display("FAIL %s: got v=%0b pos=%0d cnt=%0d lvl=%0d ovf=%0b want v=%0b pos=%0d cnt=%0d lvl=%0d ovf=%0b",
        nm, evt_valid, evt_pos, evt_count, fifo_level, overflow,
        v, p, c, l, o);
    end
  endtask

  task automatic chk2(string nm, int p, int c, int l, logic o);
    n_vec++;
    if (int'(evt_pos2) != p || int'(evt_count2) != c ||
        int'(fifo_level2) != l || overflow2 !== o) begin
      n_bad++;
      $display("FAIL %s: got pos=%0d cnt=%0d lvl=%0d ovf=%0b want pos=%0d cnt=%0d lvl=%0d ovf=%0b",
        nm, evt_pos2, evt_count2, fifo_level2, overflow2, p, c, l, o);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick2(logic bv, logic din, logic rdy, logic clr);
    bv2 = bv; din2 = din; rdy2 = rdy; clr2 = clr;
    tick();
  endtask

  initial begin
    // Test 1: stream with detections at indices 3 and 6
    add(1,0,1,0, 0,0,0,0,0);
    add(1,0,1,0, 0,0,0,0,0);
    add(1,0,1,0, 0,0,0,0,0);
    add(1,1,1,0, 1,3,1,1,0);
    add(1,0,1,0, 0,3,1,0,0);
    add(1,0,1,0, 0,3,1,0,0);
    add(1,1,1,0, 1,6,2,1,0);
    add(0,0,1,0, 0,6,2,0,0);
    add(0,0,1,0, 0,6,2,0,0);
    // Test 2: nine detections with no consumer, then drain
    add(0,0,0,1, 0,0,0,0,0);
    for (int k = 1; k <= 8; k++) add(1,1,0,0, 1,0,k,k,0);
    add(1,1,0,0, 1,OWO,9,8,1);
    for (int j = 1; j <= 7; j++) add(0,0,1,0, 1,j+OWO,9,8-j,1);
    add(0,0,1,0, 0,7+OWO,9,0,1);
    // Test 3: full FIFO, detection at 20 with a concurrent pop
    add(0,0,0,1, 0,0,0,0,0);
    for (int k = 1; k <= 8; k++) add(1,1,0,0, 1,0,k,k,0);
    for (int k = 8; k <= 19; k++) add(1,0,0,0, 1,0,8,8,0);
    add(1,1,1,0, 1,1,9,8,0);
    for (int j = 1; j <= 6; j++) add(0,0,1,0, 1,j+1,9,8-j,0);
    add(0,0,1,0, 1,20,9,1,0);
    add(0,0,1,0, 0,20,9,0,0);
    // Test 4: detector_in ignored while bit_valid is low
    add(0,0,0,1, 0,0,0,0,0);
    add(1,0,0,0, 0,0,0,0,0);
    add(1,0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 5; k++) add(0,1,0,0, 0,0,0,0,0);
    add(1,1,0,0, 1,2,1,1,0);
    // Test 6: clear together with a detection
    add(0,0,0,1, 0,0,0,0,0);
    add(1,1,0,0, 1,0,1,1,0);
    add(1,1,0,0, 1,0,2,2,0);
    add(1,1,0,0, 1,0,3,3,0);
    add(1,1,1,1, 0,0,0,0,0);
    add(1,1,0,0, 1,0,1,1,0);

    bit_valid = 0; detector_in = 0; clear = 0; evt_ready = 0;
    bv2 = 0; din2 = 0; clr2 = 0; rdy2 = 0;
    reset = 1;
    tick();
    tick();
    chk("reset", 0, 0, 0, 0, 0);
    chk2("reset2", 0, 0, 0, 0);
    reset = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      bit_valid   = tbl[i].bv;
      detector_in = tbl[i].din;
      evt_ready   = tbl[i].rdy;
      clear       = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].p,
          tbl[i].c, tbl[i].l, tbl[i].o);
    end
    bit_valid = 0; detector_in = 0; clear = 0;

    // Test 5: narrow instance, position wrap and count saturation
    tick2(0,0,0,1);
    chk2("clr2", 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) tick2(1,0,0,0);
    chk2("pre_wrap", 0, 0, 0, 0);
    tick2(1,1,0,0);
    chk2("wrap_pos", 0, 1, 1, 0);
    for (int k = 0; k < 6; k++) tick2(1,1,0,0);
    chk2("sat7", 0, 7, 7, 0);
    for (int k = 0; k < 4; k++) tick2(1,1,0,0);
    chk2("sat_hold", OWO * 3, 7, 8, 1);
    tick2(0,0,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sequence_detect_logger.md
Name: sequence_detect_logger

Overview:
- Downstream consumer of the 1011 sequence detector's detector_out.
- Tracks the bit index of the input stream.
- On each detection, records the index of the completing bit in a small FIFO.
- Drains the FIFO through a valid/ready interface; keeps a saturating detection count and a sticky overflow flag for software/bench readout.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, >= 2
- POS_W, 16: width of bit-position counter and logged position
- CNT_W, 8: width of saturating detection counter

Ports:
- clock, input, 1: rising-edge clock shared with the detector
- reset, input, 1: synchronous, active-high reset
- bit_valid, input, 1: qualifies the current cycle as carrying one stream bit
- detector_in, input, 1: detector output; sampled only when bit_valid=1
- clear, input, 1: synchronous soft clear of all state
- evt_valid, output, 1: FIFO head holds an event
- evt_ready, input, 1: consumer accepts head this cycle
- evt_pos, output, POS_W: bit index of the head event
- evt_count, output, CNT_W: total detections, saturating
- fifo_level, output, $clog2(DEPTH)+1: entries currently held
- overflow, output, 1: sticky; a detection arrived with the FIFO full

Behaviour:
- One clock domain. Reset is synchronous and active-high (port names clock, reset).
- Reset values: evt_valid=0, evt_pos=0, evt_count=0, fifo_level=0, overflow=0; internal pos=0, rd/wr pointers=0.
- Priority: reset > clear > normal operation.
  - clear has the same effect as reset.
  - A detection or pop in the same cycle as clear is discarded.
- Position counter pos:
  - Increments by 1 on every edge with bit_valid=1.
  - Wraps modulo 2^POS_W.
  - The first bit after reset/clear is index 0.
- Detection (det) = bit_valid & detector_in, sampled at the rising edge.
  - The logged value is pos before increment, i.e. the index of the bit completing the match.
  - detector_in is ignored while bit_valid=0.
- push = det. pop = evt_valid & evt_ready.
  - Not full: push writes the tail.
  - pop advances the head.
  - Simultaneous push and pop at any level, including full: both happen; level unchanged; overflow unaffected.
  - Full, push without pop: default drops the new event; see Optional Feature.
- FIFO is first-word-fall-through.
  - evt_valid = (fifo_level != 0).
  - evt_pos = head entry, driven from registered storage.
  - Latency: a detection at edge N into an empty FIFO gives evt_valid=1 and the correct evt_pos after edge N, i.e. during cycle N+1.
  - Empty FIFO: evt_ready is ignored; evt_pos holds its last value (0 after reset).
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_level is in 0..DEPTH.
- evt_count:
  - +1 on every det, including dropped events.
  - Saturates at 2^CNT_W-1; no wrap.
- overflow: set on push while full without pop; cleared only by reset/clear.

Optional Feature:
- Macro: SEQ_LOG_OVERWRITE_EN.
- Defined: on push while full without pop, the oldest entry is discarded (head advances) and the new position is written at the tail. Level stays DEPTH; overflow is still set.
- Undefined: the new event is dropped; FIFO contents are unchanged.

Test Plan:
1. Reset, evt_ready=1. Bits 1,0,1,1,0,1,1 with bit_valid=1; detector_in=1 at indices 3 and 6. -> Events evt_pos=3 then 6, each visible one cycle after its detecting edge; evt_count=2; overflow=0.
2. evt_ready=0, 9 detections at indices 0..8. -> fifo_level=8, overflow=1, evt_count=9. Drain order: 0..7 without macro; 1..8 with SEQ_LOG_OVERWRITE_EN.
3. FIFO full (positions 0..7), then detection at index 20 with evt_ready=1 in the same cycle. -> Popped value 0; level stays 8; tail=20; overflow=0.
4. detector_in=1 with bit_valid=0 for 5 cycles. -> No events; pos unchanged; evt_count unchanged.
5. POS_W=4, CNT_W=3: detection on bit index 16, then 10 more detections. -> First evt_pos=0 (wrap); evt_count=7 (saturated).
6. 3 pending events, then clear asserted together with a detection. -> Next cycle: fifo_level=0, evt_valid=0, evt_count=0, overflow=0. Next bit logs as index 0.
